msg_write_sequencer: RTL

- Sits directly downstream of the serial message receiver and sequences its byte stream into storage.
- Particle message bytes are packed into one word per particle and written to the particle memory through a req/ack handshake, cycling through particle slots.
- Map message bytes are written one byte per cycle into the map RAM at an auto-incrementing address.
- Pulses completion events for the particle set and for a full map load to the filter core.

---
 rtl/msg_write_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/msg_write_sequencer.sv
// Sequences receiver bytes into storage: particle bytes are packed into a word and
// written via req/ack to a slot; map bytes are written one per strobe to an auto-incrementing address.
module msg_write_sequencer #(
  parameter int unsigned PARTICLE_MESSAGE_LENGHT = 8,
  parameter int unsigned MAP_MESSAGE_LENGHT      = 16,
  parameter int unsigned NUM_PARTICLES           = 16,
  parameter int unsigned MAP_DEPTH_BYTES         = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [7:0]                           msg_in,
  input  logic                                 msg_valid,
  input  logic                                 particle_flag,
  input  logic                                 map_flag,
  output logic                                 particle_wr_en,
  output logic [$clog2(NUM_PARTICLES)-1:0]     particle_wr_addr,
  output logic [PARTICLE_MESSAGE_LENGHT*8-1:0] particle_wr_data,
  input  logic                                 particle_wr_ack,
  output logic                                 map_wr_en,
  output logic [$clog2(MAP_DEPTH_BYTES)-1:0]   map_wr_addr,
  output logic [7:0]                           map_wr_data,
  output logic                                 particle_set_done,
  output logic                                 map_loaded,
  output logic                                 overflow_err,
  output logic                                 protocol_err
);

  localparam int unsigned PW     = PARTICLE_MESSAGE_LENGHT * 8;
  localparam int unsigned SW     = $clog2(NUM_PARTICLES);
  localparam int unsigned AW     = $clog2(MAP_DEPTH_BYTES);
  localparam int unsigned MAXLEN = (PARTICLE_MESSAGE_LENGHT > MAP_MESSAGE_LENGHT) ?
                                   PARTICLE_MESSAGE_LENGHT : MAP_MESSAGE_LENGHT;
  localparam int unsigned CW     = $clog2(MAXLEN + 1);

  localparam logic [CW-1:0] PLEN      = CW'(PARTICLE_MESSAGE_LENGHT);
  localparam logic [CW-1:0] MLEN      = CW'(MAP_MESSAGE_LENGHT);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_PARTICLES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MAP_DEPTH_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PART, S_MAP} state_t;

  state_t          state_q, state_d;
  logic            msg_valid_q;
  logic            stb;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]   shift_q, shift_d, shift_nx;
  logic            word_done, map_wr, proto_set;

  logic            pend_q;
  logic [PW-1:0]   hold_q;
  logic [SW-1:0]   slot_q;
  logic            set_done_q, ovf_q, proto_q;
  logic            men_q, mloaded_q;
  logic [AW-1:0]   maddr_q, mptr_q;
  logic [7:0]      mdata_q;

  always_comb begin
    stb       = msg_valid & ~msg_valid_q;
    cnt_inc   = cnt_q + 1'b1;
    // Older bytes fall off the top once a full message has been shifted in,
    // so no explicit clear is needed when a new message starts.
    shift_d   = (shift_q << 8) | PW'(msg_in);
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_nx  = shift_q;
    word_done = 1'b0;
    map_wr    = 1'b0;
    proto_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (stb) begin
          if (particle_flag && !map_flag) begin
            shift_nx = shift_d;
            if (PLEN == CW'(1)) begin
              word_done = 1'b1;
            end else begin
              cnt_d   = CW'(1);
              state_d = S_PART;
            end
          end else if (map_flag && !particle_flag) begin
            map_wr = 1'b1;
            if (MLEN != CW'(1)) begin
              cnt_d   = CW'(1);
              state_d = S_MAP;
            end
          end else begin
            proto_set = 1'b1;
          end
        end
      end
      S_PART: begin
        if (!particle_flag) begin
          proto_set = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (stb) begin
          shift_nx = shift_d;
          if (cnt_inc == PLEN) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_MAP: begin
        if (!map_flag) begin
          proto_set = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (stb) begin
          map_wr = 1'b1;
          if (cnt_inc == MLEN) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_valid_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      pend_q      <= 1'b0;
      hold_q      <= '0;
      slot_q      <= '0;
      set_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
      proto_q     <= 1'b0;
      men_q       <= 1'b0;
      maddr_q     <= '0;
      mptr_q      <= '0;
      mdata_q     <= '0;
      mloaded_q   <= 1'b0;
    end else begin
      msg_valid_q <= msg_valid;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_nx;
      if (proto_set) proto_q <= 1'b1;

      set_done_q <= 1'b0;
      if (pend_q && particle_wr_ack) begin
        slot_q     <= slot_q + 1'b1;
        set_done_q <= (slot_q == LAST_SLOT);
      end
      // A completing write frees the hold register in the same cycle a new word may land.
      if (word_done) begin
        if (!pend_q || particle_wr_ack) begin
          hold_q <= shift_d;
          pend_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (pend_q && particle_wr_ack) begin
        pend_q <= 1'b0;
      end

      men_q     <= map_wr;
      mloaded_q <= 1'b0;
      if (map_wr) begin
        mdata_q   <= msg_in;
        maddr_q   <= mptr_q;
        mptr_q    <= mptr_q + 1'b1;
        mloaded_q <= (mptr_q == LAST_ADDR);
      end
    end
  end

  assign particle_wr_en    = pend_q;
  assign particle_wr_addr  = slot_q;
  assign particle_wr_data  = hold_q;
  assign particle_set_done = set_done_q;
  assign overflow_err      = ovf_q;
  assign protocol_err      = proto_q;
  assign map_wr_en         = men_q;
  assign map_wr_addr       = maddr_q;
  assign map_wr_data       = mdata_q;
  assign map_loaded        = mloaded_q;

endmodule
